// File: rtl/multi_countdown_timer_pkg.sv
// Shared types for the multi-channel countdown timer.
// Holds the channel state enum and the one-shot/periodic mode codes.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    RUN,
    EXPIRED
  } chan_state_e;

  localparam logic ONE_SHOT = 1'b0;
  localparam logic PERIODIC = 1'b1;

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond prescaler shared by all timer channels.
// Ports: clk, reset (async, active-high), tick (one cycle per ms).
module ms_tick_gen #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW =
    (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multi_countdown_timer.sv
// NUM_CH independent ms countdown channels, one-shot or periodic.
// Ports: clk, reset, load/load_ch/load_value/load_periodic, enable,
// clear_done in; timer_value, expired, done, running out (registered).
module multi_countdown_timer
  import timer_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int MAX_MS      = 3000,
  parameter int CLKS_PER_MS = 50000,
  localparam int TW = $clog2(MAX_MS + 1),
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CW-1:0]        load_ch,
  input  logic [TW-1:0]        load_value,
  input  logic                 load_periodic,
  input  logic [NUM_CH-1:0]    enable,
  input  logic [NUM_CH-1:0]    clear_done,
  output logic [NUM_CH*TW-1:0] timer_value,
  output logic [NUM_CH-1:0]    expired,
  output logic [NUM_CH-1:0]    done,
  output logic [NUM_CH-1:0]    running
);

  localparam logic [TW-1:0] MAXV = TW'(MAX_MS);

  logic tick;

  ms_tick_gen #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  logic [TW-1:0]     ld_val;
  logic [NUM_CH-1:0] ld_hit;

  assign ld_val = (load_value > MAXV) ? MAXV : load_value;

  // Out-of-range channel codes match no channel and are dropped.
  always_comb begin
    ld_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ld_hit[i] = load && (load_ch == CW'(i));
    end
  end

  chan_state_e       state_q [NUM_CH];
  logic [TW-1:0]     val_q   [NUM_CH];
  logic [TW-1:0]     rel_q   [NUM_CH];
  logic [NUM_CH-1:0] mode_q;
  logic [NUM_CH-1:0] exp_q;
  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] run_q;

  // Later assignments win: expiry set overrides clear_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        val_q[i]   <= '0;
        rel_q[i]   <= '0;
      end
      mode_q <= '0;
      exp_q  <= '0;
      done_q <= '0;
      run_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        exp_q[i] <= 1'b0;
        if (clear_done[i]) done_q[i] <= 1'b0;
        if (ld_hit[i]) begin
          val_q[i]  <= ld_val;
          rel_q[i]  <= ld_val;
          mode_q[i] <= load_periodic;
          done_q[i] <= (ld_val == '0);
          if (ld_val == '0) begin
            state_q[i] <= EXPIRED;
            run_q[i]   <= 1'b0;
          end else if (enable[i]) begin
            state_q[i] <= RUN;
            run_q[i]   <= 1'b1;
          end else begin
            state_q[i] <= LOADED;
            run_q[i]   <= 1'b0;
          end
        end else begin
          unique case (state_q[i])
            LOADED: begin
              if (enable[i]) begin
                state_q[i] <= RUN;
                run_q[i]   <= 1'b1;
              end
            end
            RUN: begin
              if (!enable[i]) begin
                state_q[i] <= LOADED;
                run_q[i]   <= 1'b0;
              end else if (tick) begin
                if (val_q[i] > TW'(1)) begin
                  val_q[i] <= val_q[i] - TW'(1);
                end else begin
                  exp_q[i]  <= 1'b1;
                  done_q[i] <= 1'b1;
                  if (mode_q[i] == PERIODIC) begin
                    val_q[i] <= rel_q[i];
                  end else begin
                    val_q[i]   <= '0;
                    state_q[i] <= EXPIRED;
                    run_q[i]   <= 1'b0;
                  end
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    timer_value = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      timer_value[i*TW +: TW] = val_q[i];
    end
  end

  assign expired = exp_q;
  assign done    = done_q;
  assign running = run_q;

endmodule

// File: tb/tb_multi_countdown_timer.sv
// Directed self-checking bench for multi_countdown_timer.
// NUM_CH=2, MAX_MS=10, CLKS_PER_MS=4: ticks every 4th edge after reset.
module tb_multi_countdown_timer;

  localparam int NCH = 2;
  localparam int MAXMS = 10;
  localparam int CPM = 4;
  localparam int TW = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           load = 1'b0;
  logic [0:0]     load_ch = '0;
  logic [TW-1:0]  load_value = '0;
  logic           load_periodic = 1'b0;
  logic [NCH-1:0] enable = '0;
  logic [NCH-1:0] clear_done = '0;
  logic [NCH*TW-1:0] timer_value;
  logic [NCH-1:0] expired;
  logic [NCH-1:0] done;
  logic [NCH-1:0] running;

  int n_assert = 0;
  int n_fail = 0;
  int edge_n = 0;

  multi_countdown_timer #(
    .NUM_CH(NCH),
    .MAX_MS(MAXMS),
    .CLKS_PER_MS(CPM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .load_ch      (load_ch),
    .load_value   (load_value),
    .load_periodic(load_periodic),
    .enable       (enable),
    .clear_done   (clear_done),
    .timer_value  (timer_value),
    .expired      (expired),
    .done         (done),
    .running      (running)
  );

  always #5 clk = ~clk;

  task automatic check_eq(string tag, int got, int exp);
    n_assert++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int v0();
    return int'(timer_value[3:0]);
  endfunction

  function automatic int v1();
    return int'(timer_value[7:4]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic to_tick();
    do step(); while (edge_n % CPM != 0);
  endtask

  task automatic to_pre_tick();
    do step(); while (edge_n % CPM != CPM - 1);
  endtask

  task automatic drive_load(int ch, int val, logic per);
    load = 1'b1;
    load_ch = ch[0:0];
    load_value = val[TW-1:0];
    load_periodic = per;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    edge_n = 0;
  endtask

  int pv;
  int pe;
  int pulses;

  initial begin
    do_reset();
    check_eq("rst_val", int'(timer_value), 0);
    check_eq("rst_exp", int'(expired), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_run", int'(running), 0);

    // one-shot countdown 3,2,1,0
    drive_load(0, 3, 1'b0);
    enable = 2'b01;
    step();
    load = 1'b0;
    check_eq("os_v3", v0(), 3);
    check_eq("os_run", int'(running[0]), 1);
    check_eq("os_done0", int'(done[0]), 0);
    to_tick();
    check_eq("os_v2", v0(), 2);
    to_tick();
    check_eq("os_v1", v0(), 1);
    check_eq("os_noexp", int'(expired[0]), 0);
    to_tick();
    check_eq("os_v0", v0(), 0);
    check_eq("os_exp", int'(expired[0]), 1);
    check_eq("os_done", int'(done[0]), 1);
    check_eq("os_stop", int'(running[0]), 0);
    step();
    check_eq("os_exp_end", int'(expired[0]), 0);
    check_eq("os_done_hold", int'(done[0]), 1);
    check_eq("os_v0_hold", v0(), 0);

    // periodic 2,1,2,1 on channel 1
    drive_load(1, 2, 1'b1);
    enable = 2'b11;
    step();
    load = 1'b0;
    check_eq("per_v2", v1(), 2);
    check_eq("per_run", int'(running[1]), 1);
    pv = 2;
    pulses = 0;
    for (int e = 0; e < 16; e++) begin
      step();
      pe = 0;
      if (edge_n % CPM == 0) begin
        if (pv == 1) begin
          pv = 2;
          pe = 1;
        end else begin
          pv = pv - 1;
        end
      end
      pulses += int'(expired[1]);
      check_eq("per_val", v1(), pv);
      check_eq("per_exp", int'(expired[1]), pe);
      check_eq("per_nz", int'(v1() == 0), 0);
    end
    check_eq("per_pulses", pulses, 2);
    check_eq("per_done", int'(done[1]), 1);

    // pause and resume on channel 0
    drive_load(0, 5, 1'b0);
    enable = 2'b01;
    step();
    load = 1'b0;
    check_eq("pz_v5", v0(), 5);
    to_tick();
    check_eq("pz_v4", v0(), 4);
    to_tick();
    check_eq("pz_v3", v0(), 3);
    enable = 2'b00;
    for (int k = 0; k < 5; k++) begin
      to_tick();
      check_eq("pz_hold", v0(), 3);
      check_eq("pz_norun", int'(running[0]), 0);
    end
    enable = 2'b01;
    step();
    check_eq("pz_resume", int'(running[0]), 1);
    check_eq("pz_v3b", v0(), 3);
    to_tick();
    check_eq("pz_v2", v0(), 2);
    to_tick();
    check_eq("pz_v1", v0(), 1);
    to_tick();
    check_eq("pz_v0", v0(), 0);
    check_eq("pz_exp", int'(expired[0]), 1);

    // clamp and zero load
    drive_load(0, 15, 1'b0);
    enable = 2'b00;
    step();
    check_eq("clamp_v", v0(), 10);
    check_eq("clamp_done", int'(done[0]), 0);
    check_eq("clamp_run", int'(running[0]), 0);
    drive_load(0, 0, 1'b0);
    step();
    load = 1'b0;
    check_eq("zero_v", v0(), 0);
    check_eq("zero_done", int'(done[0]), 1);
    check_eq("zero_exp", int'(expired[0]), 0);
    step();
    check_eq("zero_exp2", int'(expired[0]), 0);
    check_eq("zero_done2", int'(done[0]), 1);

    // load on tick edge; clear_done on expiry edge
    to_tick();
    drive_load(1, 4, 1'b0);
    enable = 2'b11;
    step();
    load = 1'b0;
    check_eq("tl_v1_4", v1(), 4);
    to_pre_tick();
    drive_load(0, 7, 1'b0);
    step();
    load = 1'b0;
    check_eq("tl_v0_7", v0(), 7);
    check_eq("tl_v1_3", v1(), 3);
    check_eq("tl_run0", int'(running[0]), 1);
    to_tick();
    check_eq("tl_v0_6", v0(), 6);
    check_eq("tl_v1_2", v1(), 2);
    to_tick();
    check_eq("tl_v1_1", v1(), 1);
    to_pre_tick();
    clear_done = 2'b10;
    step();
    check_eq("cd_exp", int'(expired[1]), 1);
    check_eq("cd_done", int'(done[1]), 1);
    check_eq("cd_v1", v1(), 0);
    check_eq("cd_v0", v0(), 4);
    step();
    clear_done = 2'b00;
    check_eq("cd_clr", int'(done[1]), 0);
    check_eq("cd_exp_end", int'(expired[1]), 0);

    // async reset with ch0 at 1
    drive_load(0, 1, 1'b0);
    enable = 2'b01;
    step();
    load = 1'b0;
    check_eq("ar_v1", v0(), 1);
    check_eq("ar_run", int'(running[0]), 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_val", int'(timer_value), 0);
    check_eq("ar_run0", int'(running), 0);
    check_eq("ar_exp", int'(expired), 0);
    check_eq("ar_done", int'(done), 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    edge_n = 0;
    for (int e = 0; e < 12; e++) begin
      step();
      check_eq("ar_noexp", int'(expired), 0);
    end
    check_eq("ar_idle_v", v0(), 0);
    check_eq("ar_idle_run", int'(running), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
